buffer_split_17_7: RTL and testbench

- Ping-pong double buffer that splits 17-bit binary totals into a stream of 7-bit per-cycle counts.
- Inverse of the accumulating double buffer in the uBrain datapath: that block folds per-cycle partial counts into a wide total; this one redistributes a wide total into bounded per-cycle counts.
- Sits between the binary result path and unary-domain consumers; each beat is at most 2^OWID-1.

---
 rtl/buffer_split_17_7_pkg.sv | 12 +
 rtl/buffer_split_17_7_split_bank.sv | 45 ++++
 rtl/buffer_split_17_7.sv | 77 +++++++
 tb/tb_buffer_split_17_7.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_split_17_7_pkg.sv
// Shared widths and constants for the total-splitting double buffer.
// Defaults match the 17-bit total / 7-bit chunk configuration.
package buffer_pkg;

  localparam int IWID_D = 17;
  localparam int OWID_D = 7;
  localparam int MAXC   = (1 << OWID_D) - 1;

  typedef logic [IWID_D-1:0] total_t;
  typedef logic [OWID_D-1:0] chunk_t;

endpackage

// File: rtl/buffer_split_17_7_split_bank.sv
// One bank of the ping-pong splitter: remaining count plus full flag.
// Emits min(rem, MAXC) per beat and flags the beat that empties it.
module split_bank
  import buffer_pkg::*;
#(
  parameter int IWID = IWID_D,
  parameter int OWID = OWID_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic [IWID-1:0] load_data,
  input  logic            beat,
  output logic            full,
  output logic [OWID-1:0] chunk,
  output logic            last
);

  localparam logic [IWID-1:0] MAXW = IWID'((1 << OWID) - 1);

  logic [IWID-1:0] rem;
  logic [IWID-1:0] chunk_w;

  assign last    = (rem <= MAXW);
  assign chunk   = last ? rem[OWID-1:0] : MAXW[OWID-1:0];
  assign chunk_w = {{(IWID-OWID){1'b0}}, chunk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      full <= 1'b0;
    end else if (clear) begin
      rem  <= '0;
      full <= 1'b0;
    end else if (load) begin
      rem  <= load_data;
      full <= 1'b1;
    end else if (beat) begin
      rem <= rem - chunk_w;
      if (last) full <= 1'b0;
    end
  end

endmodule

// File: rtl/buffer_split_17_7.sv
// Ping-pong double buffer splitting wide totals into bounded chunks.
// Top level: bank pointers, handshakes and output muxing.
module buffer_split_17_7
  import buffer_pkg::*;
#(
  parameter int IWID = IWID_D,
  parameter int OWID = OWID_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iValid,
  input  logic [IWID-1:0] iData,
  output logic            oReady,
  input  logic            iClear,
  input  logic            iHold,
  output logic            oValid,
  input  logic            iReady,
  output logic [OWID-1:0] oData,
  output logic            oLast
);

  logic            wptr;
  logic            rptr;
  logic [1:0]      full;
  logic [1:0]      last;
  logic [OWID-1:0] chunk0;
  logic [OWID-1:0] chunk1;
  logic            load_en;
  logic            beat;
  logic [OWID-1:0] rd_chunk;

  assign oReady   = ~full[wptr] & ~iClear;
  assign load_en  = iValid & oReady;
  assign oValid   = full[rptr] & ~iHold & ~iClear;
  assign beat     = oValid & iReady;
  assign rd_chunk = rptr ? chunk1 : chunk0;
  assign oData    = oValid ? rd_chunk : '0;
  assign oLast    = oValid & last[rptr];

  split_bank #(.IWID(IWID), .OWID(OWID)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (iClear),
    .load      (load_en & ~wptr),
    .load_data (iData),
    .beat      (beat & ~rptr),
    .full      (full[0]),
    .chunk     (chunk0),
    .last      (last[0])
  );

  split_bank #(.IWID(IWID), .OWID(OWID)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (iClear),
    .load      (load_en & wptr),
    .load_data (iData),
    .beat      (beat & rptr),
    .full      (full[1]),
    .chunk     (chunk1),
    .last      (last[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else if (iClear) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (load_en) wptr <= ~wptr;
      if (beat & last[rptr]) rptr <= ~rptr;
    end
  end

endmodule

// File: tb/tb_buffer_split_17_7.sv
// Self-checking bench: directed scenarios plus random traffic,
// compared against a two-entry FIFO model of pending totals.
module tb_buffer_split_17_7;
  import buffer_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   iValid;
  total_t iData;
  logic   oReady;
  logic   iClear;
  logic   iHold;
  logic   oValid;
  logic   iReady;
  chunk_t oData;
  logic   oLast;

  int checks = 0;
  int errors = 0;
  int q[$];
  int log_d[$];
  int log_l[$];

  buffer_split_17_7 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iValid (iValid),
    .iData  (iData),
    .oReady (oReady),
    .iClear (iClear),
    .iHold  (iHold),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oLast  (oLast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle from the negedge, check outputs, advance the model.
  task automatic step(input bit v, input int d, input bit clr,
                      input bit hold, input bit rdy);
    int f;
    bit e_rdy, e_val, e_last;
    int e_data;
    iValid = v;
    iData  = total_t'(d);
    iClear = clr;
    iHold  = hold;
    iReady = rdy;
    #1;
    f      = (q.size() > 0) ? q[0] : 0;
    e_rdy  = (q.size() < 2) && !clr;
    e_val  = (q.size() > 0) && !hold && !clr;
    e_data = e_val ? ((f > MAXC) ? MAXC : f) : 0;
    e_last = e_val && (f <= MAXC);
    chk("oReady", int'(oReady), int'(e_rdy));
    chk("oValid", int'(oValid), int'(e_val));
    chk("oData", int'(oData), e_data);
    chk("oLast", int'(oLast), int'(e_last));
    if (oValid && rdy) begin
      log_d.push_back(int'(oData));
      log_l.push_back(int'(oLast));
    end
    @(posedge clk);
    if (clr) q.delete();
    else begin
      if (e_val && rdy) begin
        if (e_last) void'(q.pop_front());
        else q[0] = q[0] - MAXC;
      end
      if (v && e_rdy) q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (q.size() > 0 && n < bound) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    chk({tag, "_drain_bound"}, int'(q.size() == 0), 1);
  endtask

  function automatic int log_sum();
    int s = 0;
    foreach (log_d[i]) s += log_d[i];
    return s;
  endfunction

  task automatic clr_log();
    log_d.delete();
    log_l.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    iClear = 1'b0;
    iHold  = 1'b0;
    iReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_oValid", int'(oValid), 0);
    chk("rst_oData", int'(oData), 0);
    chk("rst_oLast", int'(oLast), 0);
    chk("rst_oReady", int'(oReady), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 300 -> 127, 127, 46
    clr_log();
    step(1, 300, 0, 0, 1);
    drain("t300", 10);
    chk("t300_n", log_d.size(), 3);
    if (log_d.size() == 3) begin
      chk("t300_b0", log_d[0], 127);
      chk("t300_b1", log_d[1], 127);
      chk("t300_b2", log_d[2], 46);
      chk("t300_l0", log_l[0] + log_l[1], 0);
      chk("t300_l2", log_l[2], 1);
    end
    step(0, 0, 0, 0, 1);

    // zero total -> one beat of 0 with last
    clr_log();
    step(1, 0, 0, 0, 1);
    drain("t0", 5);
    chk("t0_n", log_d.size(), 1);
    if (log_d.size() == 1) begin
      chk("t0_d", log_d[0], 0);
      chk("t0_l", log_l[0], 1);
    end

    // back-to-back 130, 5
    clr_log();
    step(1, 130, 0, 0, 1);
    step(1, 5, 0, 0, 1);
    chk("b2b_full", int'(oReady), 0);
    drain("b2b", 10);
    chk("b2b_n", log_d.size(), 3);
    if (log_d.size() == 3) begin
      chk("b2b_b0", log_d[0], 127);
      chk("b2b_b1", log_d[1], 3);
      chk("b2b_b2", log_d[2], 5);
      chk("b2b_l", log_l[1] + log_l[2], 2);
    end

    // max total
    clr_log();
    step(1, 131071, 0, 0, 1);
    drain("tmax", 1100);
    chk("tmax_n", log_d.size(), 1033);
    chk("tmax_sum", log_sum(), 131071);
    if (log_d.size() == 1033) chk("tmax_lastd", log_d[1032], 7);

    // hold in drain cycles 2-4, iReady toggling
    clr_log();
    step(1, 300, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    for (int i = 0; i < 12 && q.size() > 0; i++)
      step(0, 0, 0, 0, bit'(i % 2));
    chk("hold_n", log_d.size(), 3);
    chk("hold_sum", log_sum(), 300);
    if (log_d.size() == 3) chk("hold_b2", log_d[2], 46);

    // clear mid-drain, then 10
    clr_log();
    step(1, 300, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 7, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    clr_log();
    step(1, 10, 0, 0, 1);
    drain("clr10", 5);
    chk("clr10_n", log_d.size(), 1);
    if (log_d.size() == 1) chk("clr10_d", log_d[0], 10);

    // reset mid-drain, then 10
    step(1, 300, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("rstm_oValid", int'(oValid), 0);
    chk("rstm_oReady", int'(oReady), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    chk("rstm_idle", int'(oValid), 0);
    clr_log();
    step(1, 10, 0, 0, 1);
    drain("rst10", 5);
    chk("rst10_n", log_d.size(), 1);
    if (log_d.size() == 1) chk("rst10_d", log_d[0], 10);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int d;
      d = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 700));
      step(bit'($urandom % 3 == 0), d, bit'($urandom % 60 == 0),
           bit'($urandom % 5 == 0), bit'($urandom % 4 != 0));
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
